// File: rtl/muldiv_types.sv
// rtl/muldiv_types.sv - shared op/state encodings and op decode helpers for muldiv_unit
package muldiv_types;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// rtl/muldiv_div_core.sv - radix-2 restoring divider on unsigned magnitudes, one bit per step
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // The dividend shifts out of quo_q from the top while quotient bits enter at the bottom.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            rem_q <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit; MULDIV_FAST_MUL_EN selects single-cycle multiplies
module muldiv_unit
    import muldiv_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_t      state_q;
    muldiv_op_t         op_q;
    logic               neg_q;
    logic               busy_q;
    logic               done_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   result_q;

    muldiv_op_t         op_in;
    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic               sign_in;
    logic               div_zero;
    logic               div_ovf;
    logic               special;
    logic               div_step;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   special_res;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   final_res;

    // Sign is applied to the full double-width product so the high half stays correct.
    function automatic logic [WIDTH-1:0] pick_mul(input logic [2*WIDTH-1:0] p, input logic neg,
                                                  input logic low);
        logic [2*WIDTH-1:0] s;
        s = neg ? -p : p;
        return low ? s[WIDTH-1:0] : s[2*WIDTH-1:WIDTH];
    endfunction

    always_comb begin
        op_in    = muldiv_op_t'(op);
        accept   = (state_q == ST_IDLE) && start && !flush;
        a_neg    = is_signed_a(op_in) && rs1[WIDTH-1];
        b_neg    = is_signed_b(op_in) && rs2[WIDTH-1];
        mag_a    = a_neg ? -rs1 : rs1;
        mag_b    = b_neg ? -rs2 : rs2;
        sign_in  = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
        div_zero = (rs2 == '0);
        div_ovf  = is_signed_a(op_in) && (rs1 == MIN_NEG) && (rs2 == '1);
        special  = is_div(op_in) && (div_zero || div_ovf);
        if (div_zero) begin
            special_res = is_rem(op_in) ? rs1 : '1;
        end else begin
            special_res = is_rem(op_in) ? '0 : rs1;
        end
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {mul_sum, prod_q[WIDTH-1:1]};
        if (is_div(op_q)) begin
            final_res = is_rem(op_q) ? (neg_q ? -rem : rem) : (neg_q ? -quo : quo);
        end else begin
            final_res = pick_mul(prod_q, neg_q, op_q == OP_MUL);
        end
        div_step = (state_q == ST_BUSY) && !cnt_q[CW-1] && !flush;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    logic [WIDTH-1:0]   fast_res;

    always_comb begin
        fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
        fast_res  = pick_mul(fast_prod, sign_in, op_in == OP_MUL);
    end
`endif

    muldiv_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .step_i     (div_step),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quotient_o (quo),
        .remainder_o(rem)
    );

    // cnt_q runs WIDTH-1 down past zero; its MSB marks the extra cycle that forms the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        op_q    <= op_in;
                        neg_q   <= sign_in;
                        mcand_q <= mag_a;
                        prod_q  <= {{WIDTH{1'b0}}, mag_b};
                        cnt_q   <= CW'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div(op_in)) begin
                            result_q <= fast_res;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
`endif
                        else begin
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q[CW-1]) begin
                        result_q <= final_res;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        prod_q <= prod_step;
                        cnt_q  <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q && !flush;
    assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit.
- Sits directly upstream of the writeback data select mux and feeds one of its data inputs.
- Accepts one operation per start pulse, stalls the pipeline via busy, and presents a registered result with a one-cycle done pulse.
- Radix-2: one bit per cycle for both multiply and divide.

Parameters:
- WIDTH, 32, operand and result width in bits; must be even and ≥4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  WIDTH  operand A (dividend / multiplicand)
- rs2  in  WIDTH  operand B (divisor / multiplier)
- flush  in  1  abort any in-flight operation
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive
- done  out  1  one-cycle pulse; result is valid in this cycle
- result  out  WIDTH  registered result; held until the next done

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0.
  - Internal accumulators and counter cleared.
  - Reset mid-operation discards the operation with no done.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and flush=0 at edge E0: latch op, rs1, rs2.
  - Signed ops convert operands to magnitudes and record the result sign.
  - Counter=WIDTH-1, go to BUSY.
  - Exception: the special divide cases below go straight to DONE.
- BUSY:
  - Each edge performs one shift-add (multiply) or one restoring shift-subtract (divide) step; counter decrements.
  - After the WIDTH-th step the result is formed and state goes to DONE.
  - Normal latency: done high in the cycle following edge E(WIDTH+1), i.e. WIDTH+1 edges after E0.
- DONE:
  - done=1, busy=1 for exactly one cycle; result updated at the edge entering DONE.
  - Next edge returns to IDLE.
  - start is ignored in BUSY and DONE; there is no queueing.
- Result selection:
  - MUL: low WIDTH bits of the product.
  - MULH/MULHSU/MULHU: high WIDTH bits of the 2*WIDTH product with signed×signed, signed×unsigned, unsigned×unsigned interpretation.
  - Final negation is applied to the full 2*WIDTH product before slicing.
- Division signs:
  - Quotient is negative iff operand signs differ.
  - Remainder takes the sign of the dividend.
- Special divide cases (1-edge latency, done in the cycle after E0):
  - Divisor=0: DIV/DIVU give all ones; REM/REMU give rs1.
  - Signed overflow (rs1=100…0, rs2=all ones, DIV/REM): quotient=rs1, remainder=0.
- flush:
  - In BUSY or DONE: next state IDLE; done forced 0 that cycle; result keeps its previous value; busy drops the next cycle.
  - flush and start together in IDLE: flush wins and the request is not accepted.
- Operands are latched at E0; later changes on rs1/rs2/op have no effect.

Optional Feature:
- MULDIV_FAST_MUL_EN
  - Defined: all four multiply ops are computed combinationally from the latched operands; state goes IDLE→DONE, so done arrives one edge after E0. Division is unchanged.
  - Undefined: multiplies use the iterative path with WIDTH+1 edge latency.
- Divide-by-zero and overflow handling are identical in both builds.

Decomposition:
- Package muldiv_types:
  - muldiv_op_t enum (the 8 funct3 encodings above)
  - muldiv_state_t enum (IDLE, BUSY, DONE)
  - helper is_div(op)/is_signed_a(op)/is_signed_b(op) functions
- Sub-module muldiv_div_core: WIDTH-iteration restoring divider on unsigned magnitudes, with step enable and quotient/remainder outputs.
- Top level owns the FSM, sign handling, multiplier datapath, special cases and result register.

Test Plan:
- Reset mid-BUSY: start MUL 7×6, assert rst_n=0 at cycle 10 → busy=0, done=0, result=0 immediately; no done afterwards.
- MUL 0xFFFFFFFF×0xFFFFFFFF and MULHU of same → results 0x00000001 and 0xFFFFFFFE; done exactly 33 edges after E0 (1 edge with MULDIV_FAST_MUL_EN).
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF(−1)×0x00000002 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each with done pulse width 1.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0; all with done one edge after E0.
- flush at cycle 5 of DIV 100/3 → no done, result unchanged; start held high during BUSY ignored; new start next IDLE cycle accepted and completes normally.
